wishbone_arbiter: RTL and testbench

Round-robin Wishbone B4 classic arbiter that shares one slave port (e.g. `wishbone_slave`) between `NUM_M` masters. It sits between the master-side agents and the single slave instance. It owns the grant, routes the handshake and response signals, honours `LOCK` for atomic sequences, and terminates hung cycles with a watchdog error.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_rr_picker.sv | 33 +++
 rtl/wishbone_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wishbone_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter FSM states and cycle-type identifiers.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TOUT = 2'd2
  } wb_arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin priority encoder: the first requester after
// index 'last' (wrapping modulo N) wins.
module wb_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          valid
);

  int c;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    c       = 0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(last) + k) % N;
      if (req[c]) begin
        gnt      = '0;
        gnt[c]   = 1'b1;
        gnt_idx  = IW'(c);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone B4 classic arbiter sharing one slave between NUM_M
// masters, with LOCK hold and a watchdog that errors out hung cycles.
//   state | meaning
//   IDLE  | no owner, GNT_O=0
//   OWN   | one master granted, slave signals routed to it
//   TOUT  | watchdog fired: one-cycle ERR to owner, STB suppressed
module wishbone_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_M     = 2,
  parameter int WB_ADDR_W = 32,
  parameter int WB_DATA_W = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                          CLK_I,
  input  logic                          RST_I,
  input  logic [NUM_M-1:0]              M_CYC_I,
  input  logic [NUM_M-1:0]              M_STB_I,
  input  logic [NUM_M-1:0]              M_WE_I,
  input  logic [NUM_M-1:0]              M_LOCK_I,
  input  logic [NUM_M*WB_ADDR_W-1:0]    M_ADR_I,
  input  logic [NUM_M*WB_DATA_W-1:0]    M_DAT_I,
  input  logic [NUM_M*WB_DATA_W/8-1:0]  M_SEL_I,
  input  logic [NUM_M*3-1:0]            M_CTI_I,
  output logic [NUM_M-1:0]              M_ACK_O,
  output logic [NUM_M-1:0]              M_ERR_O,
  output logic [NUM_M-1:0]              M_RTY_O,
  output logic [WB_DATA_W-1:0]          M_DAT_O,
  output logic [NUM_M-1:0]              GNT_O,
  output logic                          S_CYC_O,
  output logic                          S_STB_O,
  output logic                          S_WE_O,
  output logic                          S_LOCK_O,
  output logic [WB_ADDR_W-1:0]          S_ADR_O,
  output logic [WB_DATA_W-1:0]          S_DAT_O,
  output logic [WB_DATA_W/8-1:0]        S_SEL_O,
  output logic [2:0]                    S_CTI_O,
  input  logic                          S_ACK_I,
  input  logic                          S_ERR_I,
  input  logic                          S_RTY_I,
  input  logic [WB_DATA_W-1:0]          S_DAT_I
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = WB_DATA_W / 8;
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  wb_arb_state_t     state_q;
  logic [NUM_M-1:0]  gnt_q;
  logic [IW-1:0]     last_q;
  logic [7:0]        wd_cnt_q;

  logic [NUM_M-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;

  logic              owner_cyc;
  logic              owner_stb;
  logic              owner_lock;
  logic              s_term;
  logic              in_own;
  logic              in_tout;
  logic              owned;

  wb_rr_picker #(
    .N  (NUM_M),
    .IW (IW)
  ) u_picker (
    .req     (M_CYC_I),
    .last    (last_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .valid   (pick_valid)
  );

  // last_q always holds the current owner's index while one is granted.
  assign owner_cyc  = M_CYC_I[last_q];
  assign owner_stb  = M_STB_I[last_q];
  assign owner_lock = M_LOCK_I[last_q];
  assign s_term     = S_ACK_I | S_ERR_I | S_RTY_I;
  assign in_own     = (state_q == OWN);
  assign in_tout    = (state_q == TOUT);
  assign owned      = in_own | in_tout;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      last_q   <= IW'(NUM_M - 1);
      wd_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wd_cnt_q <= '0;
          if (pick_valid) begin
            gnt_q   <= pick_gnt;
            last_q  <= pick_idx;
            state_q <= OWN;
          end
        end
        OWN: begin
          if (!owner_cyc && !owner_lock) begin
            gnt_q    <= '0;
            wd_cnt_q <= '0;
            state_q  <= IDLE;
          end else if (owner_cyc && owner_stb && !s_term) begin
            // A termination in the limit cycle lands in the else branch,
            // so it wins over the timeout.
            if (wd_cnt_q >= WD_LIMIT) begin
              wd_cnt_q <= '0;
              state_q  <= TOUT;
            end else begin
              wd_cnt_q <= wd_cnt_q + 8'd1;
            end
          end else begin
            wd_cnt_q <= '0;
          end
        end
        TOUT: begin
          wd_cnt_q <= '0;
          state_q  <= OWN;
        end
        default: begin
          gnt_q    <= '0;
          wd_cnt_q <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign GNT_O = gnt_q;

  always_comb begin
    S_CYC_O  = 1'b0;
    S_STB_O  = 1'b0;
    S_WE_O   = 1'b0;
    S_LOCK_O = 1'b0;
    S_ADR_O  = '0;
    S_DAT_O  = '0;
    S_SEL_O  = '0;
    S_CTI_O  = CTI_CLASSIC;
    if (owned) begin
      S_CYC_O  = owner_cyc;
      S_STB_O  = in_own & owner_cyc & owner_stb;
      S_WE_O   = M_WE_I[last_q];
      S_LOCK_O = owner_lock;
      S_ADR_O  = M_ADR_I[int'(last_q)*WB_ADDR_W +: WB_ADDR_W];
      S_DAT_O  = M_DAT_I[int'(last_q)*WB_DATA_W +: WB_DATA_W];
      S_SEL_O  = M_SEL_I[int'(last_q)*SW +: SW];
      S_CTI_O  = M_CTI_I[int'(last_q)*3 +: 3];
    end
  end

  // Slave terminations are ignored during TOUT; the owner only sees the ERR.
  always_comb begin
    M_ACK_O = '0;
    M_ERR_O = '0;
    M_RTY_O = '0;
    if (in_own) begin
      M_ACK_O = gnt_q & {NUM_M{S_ACK_I}};
      M_ERR_O = gnt_q & {NUM_M{S_ERR_I}};
      M_RTY_O = gnt_q & {NUM_M{S_RTY_I}};
    end else if (in_tout) begin
      M_ERR_O = gnt_q;
    end
  end

  assign M_DAT_O = S_DAT_I;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a behavioural ownership model.
module tb_wishbone_arbiter;
  import wb_pkg::*;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b0;

  logic [NM-1:0] m_cyc, m_stb, m_we, m_lock;
  logic [AW-1:0] m_adr [NM];
  logic [DW-1:0] m_dat [NM];
  logic [SW-1:0] m_sel [NM];
  logic [2:0]    m_cti [NM];
  logic          s_ack, s_err, s_rty;
  logic [DW-1:0] s_dat;

  logic [NM*AW-1:0] adr_bus;
  logic [NM*DW-1:0] dat_bus;
  logic [NM*SW-1:0] sel_bus;
  logic [NM*3-1:0]  cti_bus;

  logic [NM-1:0] M_ACK_O, M_ERR_O, M_RTY_O, GNT_O;
  logic [DW-1:0] M_DAT_O;
  logic          S_CYC_O, S_STB_O, S_WE_O, S_LOCK_O;
  logic [AW-1:0] S_ADR_O;
  logic [DW-1:0] S_DAT_O;
  logic [SW-1:0] S_SEL_O;
  logic [2:0]    S_CTI_O;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: who owns the bus, whether the ERR cycle is due,
  // and how many back-to-back strobe cycles went unanswered.
  int owner = -1;
  int last  = NM - 1;
  int waitc = 0;
  bit tout  = 1'b0;
  bit mute  = 1'b0;

  always #5 CLK_I = ~CLK_I;

  always_comb begin
    adr_bus = '0;
    dat_bus = '0;
    sel_bus = '0;
    cti_bus = '0;
    for (int i = 0; i < NM; i++) begin
      adr_bus[i*AW +: AW] = m_adr[i];
      dat_bus[i*DW +: DW] = m_dat[i];
      sel_bus[i*SW +: SW] = m_sel[i];
      cti_bus[i*3 +: 3]   = m_cti[i];
    end
  end

  wishbone_arbiter #(
    .NUM_M     (NM),
    .WB_ADDR_W (AW),
    .WB_DATA_W (DW),
    .TIMEOUT   (TO)
  ) dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .M_CYC_I  (m_cyc),
    .M_STB_I  (m_stb),
    .M_WE_I   (m_we),
    .M_LOCK_I (m_lock),
    .M_ADR_I  (adr_bus),
    .M_DAT_I  (dat_bus),
    .M_SEL_I  (sel_bus),
    .M_CTI_I  (cti_bus),
    .M_ACK_O  (M_ACK_O),
    .M_ERR_O  (M_ERR_O),
    .M_RTY_O  (M_RTY_O),
    .M_DAT_O  (M_DAT_O),
    .GNT_O    (GNT_O),
    .S_CYC_O  (S_CYC_O),
    .S_STB_O  (S_STB_O),
    .S_WE_O   (S_WE_O),
    .S_LOCK_O (S_LOCK_O),
    .S_ADR_O  (S_ADR_O),
    .S_DAT_O  (S_DAT_O),
    .S_SEL_O  (S_SEL_O),
    .S_CTI_O  (S_CTI_O),
    .S_ACK_I  (s_ack),
    .S_ERR_I  (s_err),
    .S_RTY_I  (s_rty),
    .S_DAT_I  (s_dat)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_lock = '0;
    for (int i = 0; i < NM; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0; m_cti[i] = CTI_CLASSIC;
    end
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
  endtask

  task automatic model_init();
    owner = -1; last = NM - 1; waitc = 0; tout = 1'b0;
  endtask

  // Every combinational output follows from the model's owner and the
  // current inputs.
  task automatic compare_all();
    bit own;
    int o;
    own = (owner >= 0);
    o   = own ? owner : 0;
    check("gnt",    64'(GNT_O),    own ? 64'(1 << o) : 64'd0);
    check("s_cyc",  64'(S_CYC_O),  64'(own && m_cyc[o]));
    check("s_stb",  64'(S_STB_O),  64'(own && !tout && m_cyc[o] && m_stb[o]));
    check("s_we",   64'(S_WE_O),   64'(own && m_we[o]));
    check("s_lock", 64'(S_LOCK_O), 64'(own && m_lock[o]));
    check("s_adr",  64'(S_ADR_O),  own ? 64'(m_adr[o]) : 64'd0);
    check("s_dat",  64'(S_DAT_O),  own ? 64'(m_dat[o]) : 64'd0);
    check("s_sel",  64'(S_SEL_O),  own ? 64'(m_sel[o]) : 64'd0);
    check("s_cti",  64'(S_CTI_O),  own ? 64'(m_cti[o]) : 64'd0);
    check("m_ack",  64'(M_ACK_O),  (own && !tout && s_ack) ? 64'(1 << o) : 64'd0);
    check("m_err",  64'(M_ERR_O),  (own && (tout || s_err)) ? 64'(1 << o) : 64'd0);
    check("m_rty",  64'(M_RTY_O),  (own && !tout && s_rty) ? 64'(1 << o) : 64'd0);
    check("m_dat",  64'(M_DAT_O),  64'(s_dat));
  endtask

  task automatic model_update();
    if (!RST_I) begin
      model_init();
    end else if (owner < 0) begin
      if (|m_cyc) begin
        for (int k = 1; k <= NM; k++) begin
          if (owner < 0 && m_cyc[(last + k) % NM]) owner = (last + k) % NM;
        end
        last = owner;
      end
    end else if (tout) begin
      tout = 1'b0; waitc = 0;
    end else if (!m_cyc[owner] && !m_lock[owner]) begin
      owner = -1; waitc = 0;
    end else if (m_cyc[owner] && m_stb[owner] && !(s_ack || s_err || s_rty)) begin
      waitc++;
      if (waitc == TO) begin
        tout = 1'b1; waitc = 0;
      end
    end else begin
      waitc = 0;
    end
  endtask

  // Inputs are set just after a rising edge; compare, cross the edge, advance.
  task automatic step();
    #1;
    compare_all();
    @(posedge CLK_I);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    RST_I = 1'b0;
    clear_inputs();
    model_init();
    repeat (2) @(posedge CLK_I);
    #2 RST_I = 1'b1;
    @(posedge CLK_I);
    #1;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NM; i++) begin
      if (!m_cyc[i]) begin
        if ($urandom_range(3) == 0) begin
          m_cyc[i] = 1'b1;
          m_we[i]  = 1'($urandom_range(1));
          m_adr[i] = $urandom;
          m_dat[i] = $urandom;
          m_sel[i] = SW'($urandom);
          m_cti[i] = ($urandom_range(1) == 0) ? CTI_CLASSIC : CTI_EOB;
        end
      end else if ($urandom_range(4) == 0) begin
        m_cyc[i] = 1'b0;
      end
      m_stb[i] = m_cyc[i] && ($urandom_range(3) != 0);
      if (m_lock[i]) begin
        if ($urandom_range(2) == 0) m_lock[i] = 1'b0;
      end else if (m_cyc[i] && $urandom_range(7) == 0) begin
        m_lock[i] = 1'b1;
      end
    end
    if ($urandom_range(39) == 0) mute = ~mute;
    s_ack = !mute && ($urandom_range(2) == 0);
    s_err = !mute && !s_ack && ($urandom_range(19) == 0);
    s_rty = !mute && !s_ack && !s_err && ($urandom_range(19) == 0);
    s_dat = $urandom;
  endtask

  initial begin
    clear_inputs();
    model_init();
    #2;
    check("rst_gnt",  64'(GNT_O),   64'd0);
    check("rst_scyc", 64'(S_CYC_O), 64'd0);
    check("rst_sadr", 64'(S_ADR_O), 64'd0);
    do_reset();

    // Single master write
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_adr[0] = 32'h100; m_dat[0] = 32'hA5A5A5A5; m_sel[0] = 4'hF;
    step();
    check("single_gnt", 64'(GNT_O),   64'h1);
    check("single_adr", 64'(S_ADR_O), 64'h100);
    check("single_dat", 64'(S_DAT_O), 64'hA5A5A5A5);
    s_ack = 1'b1;
    #1;
    check("single_ack", 64'(M_ACK_O), 64'h1);
    step();
    clear_inputs();
    step(); step();

    // Contention from reset
    do_reset();
    m_cyc = 2'b11;
    step();
    check("cont_first", 64'(GNT_O), 64'h1);
    m_cyc[0] = 1'b0;
    step();
    check("cont_dead", 64'(GNT_O), 64'h0);
    step();
    check("cont_second", 64'(GNT_O), 64'h2);
    m_cyc = 2'b01;
    step();
    check("cont_dead2", 64'(GNT_O), 64'h0);
    step();
    check("cont_rr", 64'(GNT_O), 64'h1);
    clear_inputs();
    step(); step();

    // Lock held across a CYC gap
    m_cyc[1] = 1'b1; m_lock[1] = 1'b1;
    step();
    check("lock_gnt", 64'(GNT_O), 64'h2);
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("lock_hold", 64'(GNT_O),    64'h2);
      check("lock_scyc", 64'(S_CYC_O),  64'h0);
      check("lock_slock", 64'(S_LOCK_O), 64'h1);
    end
    m_cyc[1] = 1'b1;
    step();
    check("lock_resume", 64'(S_LOCK_O), 64'h1);
    m_cyc[1] = 1'b0; m_lock[1] = 1'b0;
    step();
    check("lock_dead", 64'(GNT_O), 64'h0);
    step();
    check("lock_next", 64'(GNT_O), 64'h1);
    clear_inputs();
    step(); step();

    // Watchdog fires after TO unanswered strobes
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    repeat (TO) step();
    check("wd_err",  64'(M_ERR_O), 64'h1);
    check("wd_stb",  64'(S_STB_O), 64'h0);
    step();
    check("wd_once", 64'(M_ERR_O), 64'h0);
    check("wd_back", 64'(S_STB_O), 64'h1);
    clear_inputs();
    step(); step();

    // Ack on the limit cycle cancels the timeout
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    repeat (TO - 1) step();
    s_ack = 1'b1;
    #1;
    check("wd_ack", 64'(M_ACK_O), 64'h1);
    step();
    s_ack = 1'b0;
    #1;
    check("wd_noerr", 64'(M_ERR_O), 64'h0);
    clear_inputs();
    step(); step();

    // Reset while M1 owns the bus
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    check("rstmid_gnt", 64'(GNT_O), 64'h2);
    RST_I = 1'b0;
    #1;
    check("rstmid_gnt0", 64'(GNT_O),   64'h0);
    check("rstmid_scyc", 64'(S_CYC_O), 64'h0);
    model_init();
    m_cyc = 2'b11;
    @(posedge CLK_I);
    #2 RST_I = 1'b1;
    step();
    check("rstmid_m0", 64'(GNT_O), 64'h1);
    clear_inputs();
    step(); step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
